// File: rtl/bwt_req_queue_if.sv
// Request-side and memory-side signals of the occurrence-table request queue.
// The master modport is the environment; the slave modport is the queue itself.
interface bwt_req_queue_if #(
  parameter int CW = 5
);
  logic          request_valid;
  logic [41:0]   addr_k;
  logic [41:0]   addr_l;
  logic [8:0]    read_num;
  logic          mem_req_ready;
  logic          mem_req_valid;
  logic [41:0]   mem_req_addr;
  logic [9:0]    mem_req_tag;
  logic          mem_req_same;
  logic          stall;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output request_valid, addr_k, addr_l, read_num, mem_req_ready,
    input  mem_req_valid, mem_req_addr, mem_req_tag, mem_req_same,
           stall, fifo_count, overflow
  );

  modport slave (
    input  request_valid, addr_k, addr_l, read_num, mem_req_ready,
    output mem_req_valid, mem_req_addr, mem_req_tag, mem_req_same,
           stall, fifo_count, overflow
  );
endinterface

// File: rtl/bwt_req_queue.sv
// Buffers k/l occurrence requests and serialises each into one (k==l) or two
// (k then l) memory read beats, throttling the control pipeline via stall.
module bwt_req_queue #(
  parameter int DEPTH = 16,
  parameter int SKID  = 4,
  parameter int CW    = 5
) (
  input logic          clk,
  input logic          rst,
  bwt_req_queue_if.slave bus
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - SKID);

  typedef struct packed {
    logic [8:0]  read_num;
    logic [41:0] addr_k;
    logic [41:0] addr_l;
  } entry_t;

  typedef enum logic [1:0] {IDLE, BEAT_K, BEAT_L} state_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic          r_valid, r_same, r_stall, r_overflow;
  logic [41:0]   r_addr;
  logic [9:0]    r_tag;

  state_t        w_state_next;
  logic          w_valid_next, w_same_next, w_load;
  logic [41:0]   w_addr_next;
  logic [9:0]    w_tag_next;
  entry_t        w_head, w_head_next, w_src;
  logic [PW-1:0] w_rptr_inc;
  logic          w_hs, w_pop, w_push;
  logic [CW-1:0] w_count_next;

  assign w_rptr_inc  = r_rptr + 1'b1;
  assign w_head      = r_mem[r_rptr];
  assign w_head_next = r_mem[w_rptr_inc];

  // An entry leaves on its final beat: a deduplicated k beat or the l beat.
  assign w_hs         = r_valid & bus.mem_req_ready;
  assign w_pop        = w_hs && ((r_state == BEAT_L) || (r_state == BEAT_K && r_same));
  assign w_push       = bus.request_valid && ((r_count != FULL) || w_pop);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_addr_next  = r_addr;
    w_tag_next   = r_tag;
    w_same_next  = r_same;
    w_load       = 1'b0;
    w_src        = w_head;

    case (r_state)
      IDLE: begin
        if (r_count != '0) w_load = 1'b1;
      end
      BEAT_K, BEAT_L: begin
        if (w_hs) begin
          if (r_state == BEAT_K && !r_same) begin
            w_state_next = BEAT_L;
            w_addr_next  = w_head.addr_l;
            w_tag_next   = {w_head.read_num, 1'b1};
            w_same_next  = 1'b0;
          end else if (r_count > CW'(1)) begin
            // Another stored entry is waiting: issue it with no bubble.
            w_load = 1'b1;
            w_src  = w_head_next;
          end else begin
            w_state_next = IDLE;
            w_valid_next = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_valid_next = 1'b0;
      end
    endcase

    if (w_load) begin
      w_state_next = BEAT_K;
      w_valid_next = 1'b1;
      w_addr_next  = w_src.addr_k;
      w_tag_next   = {w_src.read_num, 1'b0};
      w_same_next  = (w_src.addr_k == w_src.addr_l);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_tag      <= '0;
      r_same     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= w_valid_next;
      r_addr  <= w_addr_next;
      r_tag   <= w_tag_next;
      r_same  <= w_same_next;
      r_count <= w_count_next;
      r_stall <= (w_count_next >= STALL_AT);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= w_rptr_inc;
      if (bus.request_valid && !w_push) r_overflow <= 1'b1;
    end
  end

  // NOTE: the entry storage has no reset; a slot is only read once the count
  // says it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{read_num: bus.read_num, addr_k: bus.addr_k, addr_l: bus.addr_l};
  end

  assign bus.mem_req_valid = r_valid;
  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_tag   = r_tag;
  assign bus.mem_req_same  = r_same;
  assign bus.stall         = r_stall;
  assign bus.fifo_count    = r_count;
  assign bus.overflow      = r_overflow;

endmodule
